ip_injector: RTL and testbench



---
 rtl/ip_pkg.sv | 11 +
 rtl/ip_injector_if.sv | 25 ++
 rtl/ip_lane_merge.sv | 33 +++
 rtl/ip_injector.sv | 110 +++++++++++
 tb/tb_ip_injector.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ip_pkg.sv
// Purpose: shared widths, FSM state encoding and byte-offset type for the IP injector/comparator.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package ip_pkg;
  localparam int IP_W   = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, SKIP, HEAD, TAIL} inj_state_t;

  typedef logic [1:0] byte_offset_t;
endpackage

// File: rtl/ip_injector_if.sv
// Purpose: upstream/downstream word stream bundle of the IP injector.
// Latency: n/a (signal grouping only).
// Backpressure: valid/ready on both sides; master drives the stream source and the sink ready.
interface ip_injector_if;
  import ip_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [IP_W-1:0] data_in;
  logic            out_valid;
  logic            out_ready;
  logic [IP_W-1:0] data_out;

  // Source/sink side (test/replay engine and packet path)
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  // Injector side
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/ip_lane_merge.sv
// Purpose: overlays an IPv4 address onto a word at byte offset k (head part or tail part).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module ip_lane_merge
  import ip_pkg::*;
(
  input  logic [IP_W-1:0] word,
  input  logic [IP_W-1:0] ip,
  input  byte_offset_t    k,
  input  logic            en,
  input  logic            tail,
  output logic [IP_W-1:0] merged
);
  logic [5:0]      sh;
  logic [IP_W-1:0] head_mask;
  logic [IP_W-1:0] head_bits;
  logic [IP_W-1:0] tail_bits;

  // Head keeps the low 8k bits of the word; tail replaces exactly those low 8k bits
  // with the address bytes that did not fit in the head word.
  always_comb begin
    sh        = {1'b0, k, 3'b000};
    head_mask = {IP_W{1'b1}} << sh;
    head_bits = ip << sh;
    // k = 0 gives a shift of 32, which yields zero: no tail bytes exist.
    tail_bits = (ip >> (6'd32 - sh)) & ~head_mask;
    merged    = word;
    if (en) begin
      if (tail) merged = (word & head_mask) | tail_bits;
      else      merged = (word & ~head_mask) | head_bits;
    end
  end
endmodule

// File: rtl/ip_injector.sv
// Purpose: pass-through word stream that overwrites a programmed IPv4 address at a word/byte offset.
// Latency: 1 cycle input-to-output, 1 word/cycle; optional inject_count via IP_INJECTOR_COUNT_EN.
// Backpressure: in_ready = !out_valid || out_ready; output held stable while stalled.
module ip_injector
  import ip_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            arm,
  input  logic [IP_W-1:0] inject_ip,
  input  logic [7:0]      word_skip,
  input  byte_offset_t    byte_offset,
  ip_injector_if.slave    bus,
  output logic            busy,
  output logic            done
`ifdef IP_INJECTOR_COUNT_EN
  ,
  output logic [15:0]     inject_count
`endif
);
  inj_state_t      state;
  logic [IP_W-1:0] ip_q;
  byte_offset_t    k_q;
  logic [7:0]      skip_cnt;
  logic            out_valid_q;
  logic [IP_W-1:0] data_out_q;
  logic [IP_W-1:0] merged;
  logic            acc;
  logic            finish;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign busy          = (state != IDLE);
  assign acc           = bus.in_valid && bus.in_ready;
  // The word that carries the last modified byte is being accepted.
  assign finish        = acc && ((state == TAIL) || (state == HEAD && k_q == 2'd0));

  ip_lane_merge u_merge (
    .word   (bus.data_in),
    .ip     (ip_q),
    .k      (k_q),
    .en     ((state == HEAD) || (state == TAIL)),
    .tail   (state == TAIL),
    .merged (merged)
  );

  // Injection FSM together with the registered output stage and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ip_q        <= '0;
      k_q         <= '0;
      skip_cnt    <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      done        <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      ip_q        <= '0;
      k_q         <= '0;
      skip_cnt    <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      done        <= 1'b0;
    end else begin
      done <= finish;
      if (acc) begin
        out_valid_q <= 1'b1;
        data_out_q  <= merged;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          // A word accepted alongside arm passes unmodified and is not counted.
          if (arm) begin
            ip_q     <= inject_ip;
            k_q      <= byte_offset;
            skip_cnt <= word_skip;
            state    <= (word_skip == 8'd0) ? HEAD : SKIP;
          end
        end
        SKIP: begin
          if (acc) begin
            skip_cnt <= skip_cnt - 8'd1;
            if (skip_cnt == 8'd1) state <= HEAD;
          end
        end
        HEAD: begin
          if (acc) state <= (k_q == 2'd0) ? IDLE : TAIL;
        end
        TAIL: begin
          if (acc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IP_INJECTOR_COUNT_EN
  // Saturating count of completed injections.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     inject_count <= '0;
    else if (clear)                              inject_count <= '0;
    else if (finish && inject_count != 16'hFFFF) inject_count <= inject_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ip_injector.sv
// Purpose: self-checking bench for ip_injector (vector table plus stall/arm/clear sequences).
// Latency: expects 1-cycle input-to-output and done coincident with the last modified word.
// Backpressure: scoreboard pops only on out_valid && out_ready; stalls driven via out_ready.
`timescale 1ns/1ps
module tb_ip_injector;
  import ip_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         arm = 1'b0;
  logic [31:0]  inject_ip = '0;
  logic [7:0]   word_skip = '0;
  byte_offset_t byte_offset = '0;
  logic         busy;
  logic         done;
`ifdef IP_INJECTOR_COUNT_EN
  logic [15:0]  inject_count;
`endif

  ip_injector_if bus();

  ip_injector dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .arm          (arm),
    .inject_ip    (inject_ip),
    .word_skip    (word_skip),
    .byte_offset  (byte_offset),
    .bus          (bus.slave),
    .busy         (busy),
    .done         (done)
`ifdef IP_INJECTOR_COUNT_EN
    ,
    .inject_count (inject_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        dn;
  } exp_t;

  typedef struct {
    logic [31:0] ip;
    logic [7:0]  skip;
    logic [1:0]  k;
    logic [31:0] fill;
    logic [31:0] tgt;
    logic [31:0] exp_head;
    logic [31:0] exp_tail;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_exp_done = 0;
  logic prev_acc = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Output monitor: done must accompany exactly the freshly loaded word flagged in the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (prev_acc) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_underflow: fresh output word with empty scoreboard at %0t", $time);
        end else begin
          check("done_with_word", {31'b0, done}, {31'b0, sb[0].dn});
        end
      end else begin
        check("done_idle", {31'b0, done}, 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_empty: unexpected word %h at %0t", bus.data_out, $time);
        end else begin
          e = sb.pop_front();
          check("data_out", bus.data_out, e.data);
        end
      end
      prev_acc = bus.in_valid && bus.in_ready && !clear && !rst;
    end else begin
      prev_acc = 1'b0;
    end
  end

  // Called at posedge+1; clears arm after the first clock edge.
  task automatic send_word(input logic [31:0] d, input logic [31:0] exp_d, input logic exp_dn);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{exp_d, exp_dn});
        if (exp_dn) n_exp_done++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        arm = 1'b0;
        return;
      end
      @(posedge clk); #1;
      arm = 1'b0;
    end
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [31:0] ip, input logic [7:0] skip, input logic [1:0] k);
    arm = 1'b1; inject_ip = ip; word_skip = skip; byte_offset = k;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    do_arm(v.ip, v.skip, v.k);
    for (int i = 0; i < int'(v.skip); i++) send_word(v.fill, v.fill, 1'b0);
    send_word(v.tgt, v.exp_head, v.k == 2'd0);
    send_word(v.fill, v.exp_tail, v.k != 2'd0);
    repeat (2) @(posedge clk); #1;
    check("busy_after_vec", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    //            ip            skip   k     fill          tgt           exp_head      exp_tail
    tbl[0] = '{32'hC0A80001, 8'd0,   2'd0, 32'h22222222, 32'h11111111, 32'hC0A80001, 32'h22222222};
    tbl[1] = '{32'hC0A80001, 8'd2,   2'd1, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hA80001AA, 32'hAAAAAAC0};
    tbl[2] = '{32'h0A000001, 8'd0,   2'd3, 32'h00000000, 32'h00000000, 32'h01000000, 32'h000A0000};
    tbl[3] = '{32'hDEADBEEF, 8'd1,   2'd2, 32'h12345678, 32'h12345678, 32'hBEEF5678, 32'h1234DEAD};
    tbl[4] = '{32'h01020304, 8'd3,   2'd0, 32'hFFFFFFFF, 32'h00000000, 32'h01020304, 32'hFFFFFFFF};
    tbl[5] = '{32'h0A0B0C0D, 8'd0,   2'd1, 32'h00000000, 32'hFFFFFFFF, 32'h0B0C0DFF, 32'h0000000A};
    tbl[6] = '{32'h11223344, 8'd255, 2'd3, 32'h55555555, 32'h55555555, 32'h44555555, 32'h55112233};

    bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_data_out",  bus.data_out, 32'd0);
    check("rst_busy",      {31'b0, busy}, 32'd0);
    check("rst_done",      {31'b0, done}, 32'd0);
    check("rst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // arm together with an accepted word: that word passes and is not counted
    arm = 1'b1; inject_ip = 32'hCAFEF00D; word_skip = 8'd0; byte_offset = 2'd0;
    send_word(32'h33333333, 32'h33333333, 1'b0);
    send_word(32'h44444444, 32'hCAFEF00D, 1'b1);

    // arm while busy is ignored
    do_arm(32'hA5A5A5A5, 8'd1, 2'd0);
    do_arm(32'h5A5A5A5A, 8'd0, 2'd2);
    check("busy_armed", {31'b0, busy}, 32'd1);
    send_word(32'h00000000, 32'h00000000, 1'b0);
    send_word(32'h00000000, 32'hA5A5A5A5, 1'b1);
    send_word(32'h77777777, 32'h77777777, 1'b0);

    // downstream stall while the target word waits in HEAD
    do_arm(32'hC0A80001, 8'd1, 2'd1);
    bus.out_ready = 1'b0;
    send_word(32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0);
    held = bus.data_out;
    fork
      send_word(32'hAAAAAAAA, 32'hA80001AA, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready",  {31'b0, bus.in_ready}, 32'd0);
          check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
          check("stall_hold",      bus.data_out, held);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    send_word(32'hAAAAAAAA, 32'hAAAAAAC0, 1'b1);

    // clear during TAIL abandons the injection
    do_arm(32'h12345678, 8'd0, 2'd2);
    send_word(32'h00000000, 32'h56780000, 1'b0);
    check("busy_in_tail", {31'b0, busy}, 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_exp_done = 0;
    check("clr_busy",      {31'b0, busy}, 32'd0);
    check("clr_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("clr_done",      {31'b0, done}, 32'd0);
    run_vec(tbl[2]);
    run_vec(tbl[3]);

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);

`ifdef IP_INJECTOR_COUNT_EN
    check("inject_count", {16'b0, inject_count}, n_exp_done);
`endif
    mon_en = 1'b0;
    bus.in_valid = 1'b1; bus.data_in = 32'h99999999;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("rst2_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst2_data_out",  bus.data_out, 32'd0);
    check("rst2_busy",      {31'b0, busy}, 32'd0);
`ifdef IP_INJECTOR_COUNT_EN
    check("rst2_count",     {16'b0, inject_count}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
